// File: rtl/dhcp_vlg_tx.sv
// DHCP message serializer: fixed header, then options 53/50/54/61/12, then END (0xFF).
// Optional minimum-length zero padding is compiled in with `define DHCP_TX_PAD_EN.
module dhcp_vlg_tx #(
  parameter int HDR_LEN      = 240,
  parameter int MAX_HOST_LEN = 32,
  parameter int MIN_PLD_LEN  = 300
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req,
  input  logic [HDR_LEN*8-1:0]      hdr,
  input  logic [7:0]                msg_type,
  input  logic [31:0]               req_ip,
  input  logic [31:0]               srv_id,
  input  logic [47:0]               cli_mac,
  input  logic [MAX_HOST_LEN*8-1:0] host,
  input  logic [7:0]                host_len,
  input  logic [3:0]                pres,
  input  logic                      rdy,
  output logic [7:0]                dat,
  output logic                      val,
  output logic                      sof,
  output logic                      eof,
  output logic [15:0]               len,
  output logic                      busy,
  output logic                      done
);

  localparam int HB  = HDR_LEN * 8;
  localparam int HWB = MAX_HOST_LEN * 8;

  // The state names the kind of byte currently presented on dat.
  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_KIND, S_LEN, S_DATA, S_END
`ifdef DHCP_TX_PAD_EN
    , S_PAD
`endif
  } state_t;

  state_t          state;
  logic [15:0]     pos;
  logic [2:0]      opt;
  logic [7:0]      dcnt;
  logic [HB-1:0]   hdr_q;
  logic [7:0]      msg_q;
  logic [31:0]     rip_q;
  logic [31:0]     sid_q;
  logic [47:0]     mac_q;
  logic [HWB-1:0]  host_q;
  logic [7:0]      hlen_q;
  logic [3:0]      en_q;

  function automatic logic opt_en(input logic [2:0] k, input logic [3:0] en);
    case (k)
      3'd0:    opt_en = 1'b1;
      3'd1:    opt_en = en[0];
      3'd2:    opt_en = en[1];
      3'd3:    opt_en = en[2];
      3'd4:    opt_en = en[3];
      default: opt_en = 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] kind_of(input logic [2:0] k);
    case (k)
      3'd0:    kind_of = 8'd53;
      3'd1:    kind_of = 8'd50;
      3'd2:    kind_of = 8'd54;
      3'd3:    kind_of = 8'd61;
      default: kind_of = 8'd12;
    endcase
  endfunction

  function automatic logic [7:0] len_of(input logic [2:0] k, input logic [7:0] hl);
    case (k)
      3'd0:    len_of = 8'd1;
      3'd1:    len_of = 8'd4;
      3'd2:    len_of = 8'd4;
      3'd3:    len_of = 8'd7;
      default: len_of = hl;
    endcase
  endfunction

  // Request-time length and clipped hostname length, from the live inputs.
  logic [7:0]  hclip;
  logic        hon;
  logic [15:0] len_c;

  always_comb begin
    hclip = (host_len > 8'(MAX_HOST_LEN)) ? 8'(MAX_HOST_LEN) : host_len;
    hon   = pres[3] && (hclip != 8'd0);
    len_c = 16'(HDR_LEN) + 16'd4
          + (pres[0] ? 16'd6 : 16'd0)
          + (pres[1] ? 16'd6 : 16'd0)
          + (pres[2] ? 16'd9 : 16'd0)
          + (hon ? (16'd2 + {8'd0, hclip}) : 16'd0);
`ifdef DHCP_TX_PAD_EN
    if (len_c < 16'(MIN_PLD_LEN)) len_c = 16'(MIN_PLD_LEN);
`endif
  end

  // First enabled option after the current one; lowest index wins.
  logic [2:0] nxt_k;
  logic       nxt_found;

  always_comb begin
    nxt_k     = 3'd0;
    nxt_found = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      if (3'(k) > opt && opt_en(3'(k), en_q)) begin
        nxt_k     = 3'(k);
        nxt_found = 1'b1;
      end
    end
  end

  state_t          n_state;
  logic [15:0]     n_pos;
  logic [2:0]      n_opt;
  logic [7:0]      n_dcnt;
  logic [7:0]      n_dat;
  logic            n_eof;
  logic [31:0]     rip_sh;
  logic [31:0]     sid_sh;
  logic [47:0]     mac_sh;
  logic [HWB-1:0]  host_sh;

  always_comb begin
    n_state = state;
    n_pos   = pos + 16'd1;
    n_opt   = opt;
    n_dcnt  = 8'd0;
    case (state)
      S_HDR:  if (pos == 16'(HDR_LEN - 1)) begin
                n_state = S_KIND;
                n_opt   = 3'd0;
              end
      S_KIND: n_state = S_LEN;
      S_LEN:  n_state = S_DATA;
      S_DATA: if (dcnt == len_of(opt, hlen_q) - 8'd1) begin
                if (nxt_found) begin
                  n_state = S_KIND;
                  n_opt   = nxt_k;
                end else begin
                  n_state = S_END;
                end
              end else begin
                n_dcnt = dcnt + 8'd1;
              end
`ifdef DHCP_TX_PAD_EN
      S_END:  n_state = (pos == len - 16'd1) ? S_IDLE : S_PAD;
      S_PAD:  if (pos == len - 16'd1) n_state = S_IDLE;
`else
      S_END:  n_state = S_IDLE;
`endif
      default: n_state = S_IDLE;
    endcase

    rip_sh  = rip_q << {n_dcnt[1:0], 3'b000};
    sid_sh  = sid_q << {n_dcnt[1:0], 3'b000};
    mac_sh  = mac_q << {n_dcnt[2:0] - 3'd1, 3'b000};
    host_sh = host_q << {n_dcnt, 3'b000};

    case (n_state)
      S_HDR:  n_dat = hdr_q[HB-1 -: 8];
      S_KIND: n_dat = kind_of(n_opt);
      S_LEN:  n_dat = len_of(n_opt, hlen_q);
      S_DATA:
        case (n_opt)
          3'd0:    n_dat = msg_q;
          3'd1:    n_dat = rip_sh[31:24];
          3'd2:    n_dat = sid_sh[31:24];
          3'd3:    n_dat = (n_dcnt == 8'd0) ? 8'h01 : mac_sh[47:40];
          default: n_dat = host_sh[HWB-1 -: 8];
        endcase
      S_END:  n_dat = 8'hFF;
      default: n_dat = 8'h00;
    endcase

    // The last byte of the frame is whichever of END/PAD lands on len-1.
`ifdef DHCP_TX_PAD_EN
    n_eof = (n_state == S_END || n_state == S_PAD) && (n_pos == len - 16'd1);
`else
    n_eof = (n_state == S_END) && (n_pos == len - 16'd1);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      pos    <= 16'd0;
      opt    <= 3'd0;
      dcnt   <= 8'd0;
      hdr_q  <= '0;
      msg_q  <= 8'd0;
      rip_q  <= 32'd0;
      sid_q  <= 32'd0;
      mac_q  <= 48'd0;
      host_q <= '0;
      hlen_q <= 8'd0;
      en_q   <= 4'd0;
      dat    <= 8'd0;
      val    <= 1'b0;
      sof    <= 1'b0;
      eof    <= 1'b0;
      len    <= 16'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else if (state == S_IDLE) begin
      done <= 1'b0;
      if (req) begin
        msg_q  <= msg_type;
        rip_q  <= req_ip;
        sid_q  <= srv_id;
        mac_q  <= cli_mac;
        host_q <= host;
        hlen_q <= hclip;
        en_q   <= {hon, pres[2:0]};
        len    <= len_c;
        state  <= S_HDR;
        pos    <= 16'd0;
        opt    <= 3'd0;
        dcnt   <= 8'd0;
        dat    <= hdr[HB-1 -: 8];
        hdr_q  <= hdr << 8;
        val    <= 1'b1;
        sof    <= 1'b1;
        eof    <= 1'b0;
        busy   <= 1'b1;
      end
    end else if (val && rdy) begin
      if (n_state == S_IDLE) begin
        state <= S_IDLE;
        dat   <= 8'd0;
        val   <= 1'b0;
        sof   <= 1'b0;
        eof   <= 1'b0;
        busy  <= 1'b0;
        done  <= 1'b1;
      end else begin
        state <= n_state;
        pos   <= n_pos;
        opt   <= n_opt;
        dcnt  <= n_dcnt;
        dat   <= n_dat;
        sof   <= 1'b0;
        eof   <= n_eof;
        if (state == S_HDR) hdr_q <= hdr_q << 8;
      end
    end
  end

endmodule

// File: tb/tb_dhcp_vlg_tx.sv
// Self-checking bench for dhcp_vlg_tx: directed DHCP frames plus randomized frames
// under random backpressure, compared against a queue-based byte-stream model.
module tb_dhcp_vlg_tx;
  localparam int HDR_LEN = 240;
  localparam int MAXH    = 32;
  localparam int MINP    = 300;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 req;
  logic [HDR_LEN*8-1:0] hdr;
  logic [7:0]           msg_type;
  logic [31:0]          req_ip;
  logic [31:0]          srv_id;
  logic [47:0]          cli_mac;
  logic [MAXH*8-1:0]    host;
  logic [7:0]           host_len;
  logic [3:0]           pres;
  logic                 rdy;
  logic [7:0]           dat;
  logic                 val;
  logic                 sof;
  logic                 eof;
  logic [15:0]          len;
  logic                 busy;
  logic                 done;

  dhcp_vlg_tx #(.HDR_LEN(HDR_LEN), .MAX_HOST_LEN(MAXH), .MIN_PLD_LEN(MINP)) dut (
    .clk(clk), .rst(rst), .req(req), .hdr(hdr), .msg_type(msg_type), .req_ip(req_ip),
    .srv_id(srv_id), .cli_mac(cli_mac), .host(host), .host_len(host_len), .pres(pres),
    .rdy(rdy), .dat(dat), .val(val), .sof(sof), .eof(eof), .len(len), .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int sof_cnt, eof_cnt, sof_idx, eof_idx, hold_err, done_gap, len_seen, bad;
  logic done_val, done_busy, busy_first;

  function automatic int exp_len(input int raw);
`ifdef DHCP_TX_PAD_EN
    return (raw < MINP) ? MINP : raw;
`else
    return raw;
`endif
  endfunction

  // Reference: the frame written out as a list of bytes straight from the message rules.
  task automatic build_expected();
    int hl;
    exp_q.delete();
    for (int i = 0; i < HDR_LEN; i++) exp_q.push_back(hdr[(HDR_LEN-1-i)*8 +: 8]);
    exp_q.push_back(8'd53); exp_q.push_back(8'd1); exp_q.push_back(msg_type);
    if (pres[0]) begin
      exp_q.push_back(8'd50); exp_q.push_back(8'd4);
      for (int i = 3; i >= 0; i--) exp_q.push_back(req_ip[i*8 +: 8]);
    end
    if (pres[1]) begin
      exp_q.push_back(8'd54); exp_q.push_back(8'd4);
      for (int i = 3; i >= 0; i--) exp_q.push_back(srv_id[i*8 +: 8]);
    end
    if (pres[2]) begin
      exp_q.push_back(8'd61); exp_q.push_back(8'd7); exp_q.push_back(8'h01);
      for (int i = 5; i >= 0; i--) exp_q.push_back(cli_mac[i*8 +: 8]);
    end
    hl = (int'(host_len) > MAXH) ? MAXH : int'(host_len);
    if (pres[3] && hl != 0) begin
      exp_q.push_back(8'd12); exp_q.push_back(8'(hl));
      for (int i = 0; i < hl; i++) exp_q.push_back(host[(MAXH-1-i)*8 +: 8]);
    end
    exp_q.push_back(8'hFF);
`ifdef DHCP_TX_PAD_EN
    while (exp_q.size() < MINP) exp_q.push_back(8'h00);
`endif
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < HDR_LEN/4; i++) hdr[i*32 +: 32] = $urandom;
    for (int i = 0; i < MAXH/4; i++) host[i*32 +: 32] = $urandom;
    msg_type = 8'($urandom); req_ip = $urandom; srv_id = $urandom;
    cli_mac  = {16'($urandom), 32'($urandom)};
    host_len = 8'($urandom_range(0, 40));
    pres     = 4'($urandom);
  endtask

  // Issues req, scrambles inputs while busy, collects transfers until done or timeout.
  task automatic run_frame(input bit bp, input bit quick);
    int eof_cyc;
    logic [9:0] prev;
    bit prev_stall;
    build_expected();
    got_q.delete();
    sof_cnt = 0; eof_cnt = 0; sof_idx = -1; eof_idx = -1; hold_err = 0;
    done_gap = -1; done_val = 1'b1; done_busy = 1'b1; eof_cyc = -100;
    prev = '0; prev_stall = 1'b0;
    if (!quick) @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    randomize_inputs();
    len_seen = int'(len);
    busy_first = busy;
    for (int c = 0; c < 4000; c++) begin
      if (c > 0) @(negedge clk);
      rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall && {dat, sof, eof} !== prev) hold_err++;
      if (done) begin
        done_gap = c - eof_cyc; done_val = val; done_busy = busy;
        break;
      end
      prev_stall = 1'b0;
      if (val && rdy) begin
        got_q.push_back(dat);
        if (sof) begin sof_cnt++; sof_idx = got_q.size() - 1; end
        if (eof) begin eof_cnt++; eof_idx = got_q.size() - 1; eof_cyc = c; end
      end else if (val) begin
        prev_stall = 1'b1; prev = {dat, sof, eof};
      end
    end
    rdy = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; rdy = 1'b1;
    randomize_inputs();
    repeat (3) @(negedge clk);
    checks++;
    if ({dat, val, sof, eof, len, busy, done} !== 29'd0) begin
      errors++;
      $display("FAIL reset_outputs: got dat=%h val=%b sof=%b eof=%b len=%0d busy=%b done=%b, want all 0",
               dat, val, sof, eof, len, busy, done);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_discover();
    logic [7:0] tail [13] = '{8'h35, 8'h01, 8'h01, 8'h3D, 8'h07, 8'h01, 8'h02,
                              8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'hFF};
    randomize_inputs();
    msg_type = 8'd1; pres = 4'b0100; cli_mac = 48'h02_00_00_00_00_01;
    run_frame(1'b0, 1'b0);
    checks++;
    if (len_seen !== exp_len(253) || busy_first !== 1'b1) begin
      errors++; $display("FAIL discover_len: got len=%0d busy=%b, want len=%0d busy=1",
                         len_seen, busy_first, exp_len(253));
    end
    bad = (got_q.size() < 253) ? 1 : 0;
    for (int i = 0; i < 13 && bad == 0; i++) if (got_q[240+i] !== tail[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL discover_tail: bytes 240..252 differ (frame size %0d)", got_q.size());
    end
`ifdef DHCP_TX_PAD_EN
    bad = 0;
    for (int i = 253; i < 300 && i < got_q.size(); i++) if (got_q[i] !== 8'h00) bad++;
    checks++;
    if (bad != 0 || eof_idx != 299) begin
      errors++; $display("FAIL discover_pad: nonzero pad=%0d eof_idx=%0d, want 0 and 299", bad, eof_idx);
    end
`else
    checks++;
    if (eof_idx != 252 || done_gap != 1) begin
      errors++; $display("FAIL discover_eof: eof_idx=%0d done_gap=%0d, want 252 and 1", eof_idx, done_gap);
    end
`endif
  endtask

  task automatic test_request();
    logic [7:0] tail [16] = '{8'h35, 8'h01, 8'h03, 8'h32, 8'h04, 8'hC0, 8'hA8, 8'h01, 8'h64,
                              8'h36, 8'h04, 8'hC0, 8'hA8, 8'h01, 8'h01, 8'hFF};
    randomize_inputs();
    msg_type = 8'd3; pres = 4'b0011; req_ip = 32'hC0A80164; srv_id = 32'hC0A80101;
    run_frame(1'b0, 1'b0);
    bad = (got_q.size() < 256) ? 1 : 0;
    for (int i = 0; i < 16 && bad == 0; i++) if (got_q[240+i] !== tail[i]) bad++;
    checks++;
    if (bad != 0 || len_seen !== exp_len(256)) begin
      errors++; $display("FAIL request_frame: len=%0d want %0d, tail mismatch=%0d",
                         len_seen, exp_len(256), bad);
    end
  endtask

  task automatic test_hostname();
    logic [7:0] tail [7] = '{8'h0C, 8'h04, 8'h66, 8'h70, 8'h67, 8'h61, 8'hFF};
    randomize_inputs();
    pres = 4'b1000; host_len = 8'd4; host = {32'h66706761, {(MAXH*8-32){1'b0}}};
    run_frame(1'b0, 1'b0);
    bad = (got_q.size() < 250) ? 1 : 0;
    for (int i = 0; i < 7 && bad == 0; i++) if (got_q[243+i] !== tail[i]) bad++;
    checks++;
    if (bad != 0 || len_seen !== exp_len(250)) begin
      errors++; $display("FAIL hostname_opt: len=%0d want %0d, tail mismatch=%0d",
                         len_seen, exp_len(250), bad);
    end
    randomize_inputs();
    pres = 4'b1000; host_len = 8'd0;
    run_frame(1'b0, 1'b0);
    checks++;
    if (len_seen !== exp_len(244) || got_q.size() < 244 || got_q[243] !== 8'hFF) begin
      errors++; $display("FAIL hostlen_zero: len=%0d size=%0d want len %0d and byte 243 = FF",
                         len_seen, got_q.size(), exp_len(244));
    end
  endtask

  task automatic test_random_backpressure();
    for (int n = 0; n < 8; n++) begin
      randomize_inputs();
      run_frame(n != 0, 1'b0);
      bad = (got_q.size() != exp_q.size()) ? 1 : 0;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
      checks++;
      if (bad != 0 || len_seen != exp_q.size()) begin
        errors++; $display("FAIL stream_%0d: size=%0d len=%0d want %0d, byte mismatches=%0d",
                           n, got_q.size(), len_seen, exp_q.size(), bad);
      end
      checks++;
      if (sof_cnt != 1 || sof_idx != 0 || eof_cnt != 1 || eof_idx != exp_q.size() - 1 ||
          hold_err != 0 || done_gap != 1 || done_val !== 1'b0 || done_busy !== 1'b0) begin
        errors++; $display("FAIL markers_%0d: sof=%0d@%0d eof=%0d@%0d hold_err=%0d done_gap=%0d want 1@0 1@%0d 0 1",
                           n, sof_cnt, sof_idx, eof_cnt, eof_idx, hold_err, done_gap, exp_q.size() - 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    randomize_inputs();
    run_frame(1'b0, 1'b0);
    randomize_inputs();
    run_frame(1'b1, 1'b1);
    bad = (got_q.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0 || sof_idx != 0 || eof_idx != exp_q.size() - 1 || done_gap != 1) begin
      errors++; $display("FAIL back_to_back: mismatches=%0d sof_idx=%0d eof_idx=%0d done_gap=%0d", bad,
                         sof_idx, eof_idx, done_gap);
    end
  endtask

  task automatic test_midframe_reset();
    int n;
    int seen_eof;
    int seen_done;
    randomize_inputs();
    pres = 4'b1111;
    n = 0; seen_eof = 0; seen_done = 0;
    @(negedge clk); req = 1'b1;
    @(negedge clk); req = 1'b0; rdy = 1'b1;
    for (int c = 0; c < 500 && n < 100; c++) begin
      if (val && eof) seen_eof++;
      if (val) n++;
      if (n < 100) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({val, sof, eof, busy, done} !== 5'd0 || seen_eof != 0 || n != 100) begin
      errors++; $display("FAIL midframe_rst: val=%b sof=%b eof=%b busy=%b done=%b eofs=%0d bytes=%0d",
                         val, sof, eof, busy, done, seen_eof, n);
    end
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done || val) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      errors++; $display("FAIL midframe_quiet: %0d cycles with done/val after reset, want 0", seen_done);
    end
    randomize_inputs();
    run_frame(1'b1, 1'b0);
    bad = (got_q.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0 || sof_idx != 0 || eof_cnt != 1 || done_gap != 1) begin
      errors++; $display("FAIL after_rst_frame: mismatches=%0d sof_idx=%0d eof_cnt=%0d done_gap=%0d",
                         bad, sof_idx, eof_cnt, done_gap);
    end
  endtask

  initial begin
    test_reset();
    test_discover();
    test_request();
    test_hostname();
    test_random_backpressure();
    test_back_to_back();
    test_midframe_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
